// File: rtl/fb_writer.sv
// Framebuffer writer: packs RGB888 pixels to RGB565, tags each with its raster
// address, buffers them in a FIFO and drains them to memory under valid/ready.
module fb_writer #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              valid_pix,
    input  logic [7:0]        R,
    input  logic [7:0]        G,
    input  logic [7:0]        B,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = ADDR_W + 16;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic [ADDR_W-1:0] in_cnt_q,     in_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0]  count_q,      count_d;
    logic              out_valid_q,  out_valid_d;
    logic [ADDR_W-1:0] out_addr_q,   out_addr_d;
    logic [15:0]       out_data_q,   out_data_d;
    logic              overflow_q,   overflow_d;
    logic              frame_done_q, frame_done_d;

    logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];

    logic               pix_seen;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push;
    logic               drop;
    logic               pipe_empty_next;
    logic [15:0]        rgb565;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Low colour bits are truncated by the RGB565 packing.
    logic unused_low_bits;
    assign unused_low_bits = ^{R[2:0], G[1:0], B[2:0]};

    always_comb begin
        rgb565     = {R[7:3], G[7:2], B[7:3]};
        push_entry = {in_cnt_q, rgb565};
        head_entry = fifo_mem_q[rd_ptr_q];

        pix_seen   = (state_q == ST_ACTIVE) && valid_pix;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        // The output register frees up either when empty or when its write completes.
        pop        = !fifo_empty && (!out_valid_q || mem_ready);
        push       = pix_seen && (!fifo_full || pop);
        drop       = pix_seen && fifo_full && !pop;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        if (pop) begin
            out_valid_d              = 1'b1;
            {out_addr_d, out_data_d} = head_entry;
        end else if (mem_ready) begin
            out_valid_d = 1'b0;
        end

        pipe_empty_next = (count_d == '0) && !out_valid_d;
    end

    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        overflow_d   = overflow_q | drop;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d    = ST_ACTIVE;
                    in_cnt_d   = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_ACTIVE: begin
                // Dropped pixels still advance the address so later pixels land in place.
                if (valid_pix) begin
                    in_cnt_d = in_cnt_q + ADDR_W'(1);
                    if (in_cnt_q == LAST_PIX) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leaving on the final handshake puts frame_done after busy falls.
                if (pipe_empty_next) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            in_cnt_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign mem_we     = out_valid_q;
    assign mem_addr   = out_addr_q;
    assign mem_wdata  = out_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: a colour table for the RGB565 packing plus
// hand-written frames for latency, backpressure, overflow, ignored inputs and reset.
module tb_fb_writer;

    localparam int unsigned H     = 8;
    localparam int unsigned V     = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 10;
    localparam int NPIX = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          valid_pix = 1'b0;
    logic [7:0]    R = '0;
    logic [7:0]    G = '0;
    logic [7:0]    B = '0;
    logic          mem_ready = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          busy;
    logic          frame_done;
    logic          overflow;

    always #5 clk = ~clk;

    fb_writer #(
        .H_RES(H),
        .V_RES(V),
        .FIFO_DEPTH(DEPTH),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .valid_pix(valid_pix),
        .R(R),
        .G(G),
        .B(B),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .busy(busy),
        .frame_done(frame_done),
        .overflow(overflow)
    );

    typedef struct {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [15:0] d;
    } vec_t;

    vec_t tbl[8];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int obs_a[$];
    int obs_d[$];
    int obs_c[$];
    int exp_a[$];
    int exp_d[$];

    int stall_viol = 0;
    int overlap_viol = 0;
    int fd_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [15:0]   prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (mem_we && mem_ready) begin
                obs_a.push_back(int'(mem_addr));
                obs_d.push_back(int'(mem_wdata));
                obs_c.push_back(cyc);
            end
            if (prev_stall && (!mem_we || mem_addr != prev_addr || mem_wdata != prev_data))
                stall_viol++;
            prev_stall = mem_we && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
            if (frame_done) fd_cnt++;
            if (frame_done && busy) overlap_viol++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        valid_pix = 1'b1;
        R = r;
        G = g;
        B = b;
        tick();
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (frame_done !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check({name, "_seen"}, 32'(frame_done), 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic compare_obs(input string name, input int base);
        int n;
        n = obs_a.size() - base;
        check({name, "_count"}, n, exp_a.size());
        for (int k = 0; k < exp_a.size() && k < n; k++) begin
            check($sformatf("%s_addr%0d", name, k), obs_a[base + k], exp_a[k]);
            check($sformatf("%s_data%0d", name, k), obs_d[base + k], exp_d[k]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int fd0;

        tbl[0] = '{8'hFF, 8'h80, 8'h08, 16'hFC01};
        tbl[1] = '{8'h00, 8'h00, 8'h00, 16'h0000};
        tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 16'hFFFF};
        tbl[3] = '{8'hFF, 8'h00, 8'h00, 16'hF800};
        tbl[4] = '{8'h00, 8'hFF, 8'h00, 16'h07E0};
        tbl[5] = '{8'h00, 8'h00, 8'hFF, 16'h001F};
        tbl[6] = '{8'h08, 8'h04, 8'h08, 16'h0821};
        tbl[7] = '{8'h12, 8'h34, 8'h56, 16'h11AA};

        // Reset state
        repeat (3) tick();
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_data", 32'(mem_wdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 0);

        // Basic frame: colour table then default pixels, full throughput
        mem_ready = 1'b1;
        base = obs_a.size();
        fd0 = fd_cnt;
        pulse_start();
        check("basic_busy", 32'(busy), 1);
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < NPIX; i++) begin
            exp_a.push_back(i);
            if (i < 8) begin
                exp_d.push_back(int'(tbl[i].d));
                send(tbl[i].r, tbl[i].g, tbl[i].b);
            end else begin
                exp_d.push_back(32'hFC01);
                send(8'hFF, 8'h80, 8'h08);
            end
            if (i == 0) check("lat_c1_we", 32'(mem_we), 0);
            if (i == 1) begin
                check("lat_c2_we", 32'(mem_we), 1);
                check("lat_c2_addr", 32'(mem_addr), 0);
                check("lat_c2_data", 32'(mem_wdata), 32'hFC01);
            end
        end
        valid_pix = 1'b0;
        wait_done("basic_done");
        tick();
        tick();
        check("basic_fd_once", fd_cnt - fd0, 1);
        check("basic_ovf", 32'(overflow), 0);
        compare_obs("basic", base);

        // Backpressure: 8 pixels stalled, then released
        mem_ready = 1'b0;
        base = obs_a.size();
        pulse_start();
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < 8; i++) begin
            exp_a.push_back(i);
            exp_d.push_back(int'(tbl[i].d));
            send(tbl[i].r, tbl[i].g, tbl[i].b);
        end
        valid_pix = 1'b0;
        repeat (3) tick();
        check("bp_stall_we", 32'(mem_we), 1);
        check("bp_stall_addr", 32'(mem_addr), 0);
        check("bp_stall_data", 32'(mem_wdata), 32'hFC01);
        check("bp_stall_ovf", 32'(overflow), 0);
        mem_ready = 1'b1;
        for (int i = 8; i < NPIX; i++) begin
            exp_a.push_back(i);
            exp_d.push_back(32'hFC01);
            send(8'hFF, 8'h80, 8'h08);
        end
        valid_pix = 1'b0;
        wait_done("bp_done");
        compare_obs("bp", base);
        if (obs_c.size() >= base + 8)
            check("bp_back_to_back", obs_c[base + 7] - obs_c[base], 7);
        else
            check("bp_back_to_back_count", obs_c.size() - base, 8);
        check("bp_ovf", 32'(overflow), 0);
        check("bp_stable", stall_viol, 0);

        // Overflow: 20 pixels into a stalled pipeline, 17..19 dropped
        mem_ready = 1'b0;
        base = obs_a.size();
        pulse_start();
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < 20; i++) begin
            if (i <= 16) begin
                exp_a.push_back(i);
                exp_d.push_back(i << 11);
            end
            send(8'(i * 8), 8'h00, 8'h00);
            if (i == 16) check("ovf_at_full", 32'(overflow), 0);
            if (i == 17) check("ovf_on_drop", 32'(overflow), 1);
        end
        check("ovf_hold_addr", 32'(mem_addr), 0);
        mem_ready = 1'b1;
        for (int i = 20; i < NPIX; i++) begin
            exp_a.push_back(i);
            exp_d.push_back(i << 11);
            send(8'(i * 8), 8'h00, 8'h00);
        end
        valid_pix = 1'b0;
        wait_done("ovf_done");
        compare_obs("ovf", base);
        check("ovf_sticky_done", 32'(overflow), 1);
        repeat (3) tick();
        check("ovf_sticky_idle", 32'(overflow), 1);

        // Full FIFO with a simultaneous pop: no drop
        base = obs_a.size();
        pulse_start();
        check("ovf_cleared", 32'(overflow), 0);
        mem_ready = 1'b0;
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < 17; i++) begin
            exp_a.push_back(i);
            exp_d.push_back(i << 11);
            send(8'(i * 8), 8'h00, 8'h00);
        end
        valid_pix = 1'b0;
        tick();
        check("full_hold_ovf", 32'(overflow), 0);
        mem_ready = 1'b1;
        for (int i = 17; i < NPIX; i++) begin
            exp_a.push_back(i);
            exp_d.push_back(i << 11);
            send(8'(i * 8), 8'h00, 8'h00);
        end
        valid_pix = 1'b0;
        check("full_pop_ovf", 32'(overflow), 0);
        wait_done("full_done");
        compare_obs("full", base);

        // Ignored inputs: valid_pix in IDLE/DRAIN, frame_start mid-frame
        base = obs_a.size();
        for (int i = 0; i < 4; i++) send(8'hAA, 8'hBB, 8'hCC);
        valid_pix = 1'b0;
        repeat (3) tick();
        check("idle_no_write", obs_a.size() - base, 0);
        check("idle_no_busy", 32'(busy), 0);
        pulse_start();
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < NPIX; i++) begin
            exp_a.push_back(i);
            exp_d.push_back(int'(tbl[i % 8].d));
            if (i == 10) frame_start = 1'b1;
            send(tbl[i % 8].r, tbl[i % 8].g, tbl[i % 8].b);
            frame_start = 1'b0;
        end
        send(8'h11, 8'h22, 8'h33);
        send(8'h44, 8'h55, 8'h66);
        valid_pix = 1'b0;
        wait_done("ign_done");
        tick();
        compare_obs("ign", base);

        // Reset mid-frame with a stalled pipeline
        mem_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 3; i++) send(8'hFF, 8'hFF, 8'hFF);
        valid_pix = 1'b0;
        check("mid_we_before", 32'(mem_we), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_we", 32'(mem_we), 0);
        check("mid_rst_busy", 32'(busy), 0);
        base = obs_a.size();
        mem_ready = 1'b1;
        repeat (4) tick();
        check("mid_rst_no_write", obs_a.size() - base, 0);
        pulse_start();
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < NPIX; i++) begin
            exp_a.push_back(i);
            exp_d.push_back(i << 11);
            send(8'(i * 8), 8'h00, 8'h00);
        end
        valid_pix = 1'b0;
        wait_done("restart_done");
        compare_obs("restart", base);

        tick();
        check("overlap_done_busy", overlap_viol, 0);
        check("stall_stable_all", stall_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
